data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL provide parameter DEPTH, default 32, number of 32-bit data words stored.
REQ-002 SHALL provide parameter WAIT_STATES, default 2, number of wait cycles between request acceptance and response (legal range 0..15).
REQ-003 SHALL provide port clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL provide port reset, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL provide port req_valid, input, 1, initiator presents a request.
REQ-006 SHALL provide port req_ready, output, 1, responder accepts a request this cycle.
REQ-007 SHALL provide port req_write, input, 1, 1 = store, 0 = load.
REQ-008 SHALL provide port req_addr, input, 32, byte address; word index = req_addr[31:2].
REQ-009 SHALL provide port req_wdata, input, 32, store data.
REQ-010 SHALL provide port req_wstrb, input, 4, byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-011 SHALL provide port rsp_valid, output, 1, response is present.
REQ-012 SHALL provide port rsp_ready, input, 1, initiator accepts the response.
REQ-013 SHALL provide port rsp_rdata, output, 32, load data; 0 for stores and errors.
REQ-014 SHALL provide port rsp_err, output, 1, access fault flag for the response.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP, with exactly one transaction outstanding.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clock edge where req_valid && req_ready.
REQ-017 SHALL latch req_write, req_addr, req_wdata and req_wstrb on acceptance; later input changes SHALL NOT affect the transaction.
REQ-018 SHALL move from IDLE to WAIT on acceptance and load a wait counter with WAIT_STATES; with WAIT_STATES=0 it SHALL go directly to RESP.
REQ-019 SHALL decrement the counter in WAIT and enter RESP on the edge where the counter reaches 0.
REQ-020 SHALL raise rsp_valid exactly WAIT_STATES+1 cycles after the acceptance edge.
REQ-021 SHALL commit a store to the array on the same edge that rsp_valid rises, never earlier.
REQ-022 SHALL, for a load, sample the word into rsp_rdata on that edge and hold it stable with rsp_err while rsp_valid=1.
REQ-023 SHALL hold RESP until rsp_valid && rsp_ready, then return to IDLE with req_ready=1 in the next cycle (no back-to-back acceptance in the handshake cycle).
REQ-024 SHALL flag rsp_err=1 when word index >= DEPTH or req_addr[1:0] != 0; a faulted store SHALL NOT modify any word; a faulted load SHALL return 0.
REQ-025 SHALL treat a store with req_wstrb=4'b0000 as a successful no-op (rsp_err=0).
REQ-026 SHALL keep req_ready=0 in WAIT and RESP regardless of req_valid.

Reset
REQ-027 SHALL, while reset=0 at a rising edge, force state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and clear all DEPTH words to 0.
REQ-028 SHALL hold req_ready=0 while reset=0 and drive req_ready=1 in the first cycle after release.
REQ-029 SHALL abandon any in-flight transaction on reset: no pending store commits and no response is issued.

Configuration
REQ-030 SHALL, when DMEM_BYTE_STROBE_EN is defined, update only the byte lanes enabled by the latched req_wstrb.
REQ-031 SHALL, when DMEM_BYTE_STROBE_EN is undefined, ignore req_wstrb and write all 32 bits on every non-faulted store; REQ-025 then does not apply.

Verification
REQ-032 SHALL check: WAIT_STATES=2, store addr 0x08 data 0xDEADBEEF wstrb 0xF accepted at cycle 0 -> rsp_valid=1 at cycle 3 with rsp_err=0; a later load of 0x08 returns 0xDEADBEEF.
REQ-033 SHALL check: with DMEM_BYTE_STROBE_EN, word 0x08=0xDEADBEEF, then store 0x11223344 with wstrb 0x3 -> load returns 0xDEAD3344; without the macro the load returns 0x11223344.
REQ-034 SHALL check: load addr 0x80 with DEPTH=32, then store to 0x0A -> both responses have rsp_err=1, load rdata=0, and the store leaves memory unchanged.
REQ-035 SHALL check: response backpressure with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stay stable, req_ready=0, and a new req_valid is not accepted until 1 cycle after the handshake.
REQ-036 SHALL check: a store to 0x04 followed by reset=0 in the WAIT state -> no response is issued, word 0x04 reads back 0, and req_ready=1 in the first cycle after release.
REQ-037 SHALL check: WAIT_STATES=0, load accepted at cycle 0 -> rsp_valid=1 at cycle 1.

Source files
------------

// File: rtl/data_mem_if.sv
// data_mem_if: request/response bus between a data-memory initiator and responder.
//   master: drives req_valid/req_write/req_addr/req_wdata/req_wstrb and rsp_ready
//   slave : drives req_ready and rsp_valid/rsp_rdata/rsp_err
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding word memory with a fixed response delay.
//   clk   : rising-edge clock for all state
//   reset : synchronous, active-low; clears FSM, response regs and every word
//   bus   : data_mem_if.slave request/response channel
//   DMEM_BYTE_STROBE_EN (macro): when defined, stores honour req_wstrb per byte lane;
//   otherwise every non-faulted store writes the full word.
module data_mem_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 2
) (
  input logic       clk,
  input logic       reset,
  data_mem_if.slave bus
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [DEPTH];
  logic        acc, fire, done, c_wr, c_err;
  logic [31:0] c_addr, c_wdata, c_word, merged;
  logic [AW-1:0] c_idx;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  wstrb_q, c_wstrb;
`endif
  assign bus.req_ready = reset && state == IDLE;
  assign acc  = bus.req_valid && bus.req_ready;
  assign done = bus.rsp_valid && bus.rsp_ready;
  // With zero wait states the access completes on the acceptance edge itself,
  // so the live request is used in IDLE and the latched copy afterwards.
  always_comb begin
    c_wr    = state == IDLE ? bus.req_write : wr_q;
    c_addr  = state == IDLE ? bus.req_addr  : addr_q;
    c_wdata = state == IDLE ? bus.req_wdata : wdata_q;
    c_err   = ({2'b0, c_addr[31:2]} >= 32'(DEPTH)) || c_addr[1:0] != 2'b00;
    c_idx   = c_addr[AW+1:2];
    c_word  = c_err ? '0 : mem[c_idx];
  end
`ifdef DMEM_BYTE_STROBE_EN
  always_comb begin
    c_wstrb = state == IDLE ? bus.req_wstrb : wstrb_q;
    merged  = c_word;
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = c_wstrb[i] ? c_wdata[8*i +: 8] : c_word[8*i +: 8];
  end
`else
  assign merged = c_wdata;
`endif
  // fire marks the edge that enters RESP: store commit and load sampling happen there.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fire     = 1'b0;
    case (state)
      IDLE: if (acc) begin
        if (WAIT_STATES == 0) begin
          state_nx = RESP;
          fire     = 1'b1;
        end else begin
          state_nx = WAIT;
          cnt_nx   = 4'(WAIT_STATES);
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = RESP;
          fire     = 1'b1;
        end
      end
      RESP: state_nx = done ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
`ifdef DMEM_BYTE_STROBE_EN
      wstrb_q       <= '0;
`endif
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (acc) begin
        wr_q    <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
        wstrb_q <= bus.req_wstrb;
`endif
      end
      if (fire) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_rdata <= c_wr ? '0 : c_word;
        bus.rsp_err   <= c_err;
        if (c_wr && !c_err) mem[c_idx] <= merged;
      end else if (done) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized self-checking bench with a word-array reference model.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  data_mem_if b ();
  data_mem_if b0 ();
  data_mem_responder #(.DEPTH(32), .WAIT_STATES(2)) dut  (.clk(clk), .reset(reset), .bus(b.slave));
  data_mem_responder #(.DEPTH(32), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  int total = 0;
  int bad = 0;
  logic [31:0] model [32];

  function automatic logic fault(input logic [31:0] a);
    return (a >> 2) >= 32 || a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] r;
    r = wd;
`ifdef DMEM_BYTE_STROBE_EN
    r = old;
    for (int i = 0; i < 4; i++) if (ws[i]) r[8*i +: 8] = wd[8*i +: 8];
`endif
    return r;
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] a);
    return fault(a) ? 32'h0 : model[a[6:2]];
  endfunction

  task automatic mstore(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    if (!fault(a)) model[a[6:2]] = merge(model[a[6:2]], wd, ws);
  endtask

  task automatic mclear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Runs one transaction on the WAIT_STATES=2 responder; lat counts falling edges
  // from the acceptance edge until rsp_valid is seen (-1 if it never appears).
  task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd, output logic er, output int lat);
    int w;
    @(negedge clk);
    b.req_valid = 1'b1; b.req_write = wr; b.req_addr = a; b.req_wdata = wd; b.req_wstrb = ws;
    w = 0;
    while (!b.req_ready && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    b.req_valid = 1'b0; b.req_write = ~wr; b.req_addr = $urandom; b.req_wdata = $urandom; b.req_wstrb = 4'($urandom);
    lat = 1;
    while (!b.rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!b.rsp_valid) lat = -1;
    rd = b.rsp_rdata; er = b.rsp_err;
    b.rsp_ready = 1'b1;
    @(negedge clk);
    b.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (b.req_ready !== 1'b0 || b0.req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b/%b want=0/0", b.req_ready, b0.req_ready); end
    total++;
    if (b.rsp_valid !== 1'b0 || b.rsp_rdata !== 32'h0 || b.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp got v=%b d=%h e=%b want 0/0/0", b.rsp_valid, b.rsp_rdata, b.rsp_err); end
    reset = 1'b1;
    mclear();
    @(negedge clk);
    total++;
    if (b.req_ready !== 1'b1 || b0.req_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b/%b want=1/1", b.req_ready, b0.req_ready); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rd, er, lat);
    mstore(32'h8, 32'hDEADBEEF, 4'hF);
    total++;
    if (lat != 3 || er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL store_rsp got lat=%0d e=%b d=%h want 3/0/0", lat, er, rd); end
    txn(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (lat != 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rsp got lat=%0d e=%b d=%h want 3/0/deadbeef", lat, er, rd); end
  endtask

  task automatic test_strobe();
    logic [31:0] rd, want; logic er; int lat;
    txn(1'b1, 32'h8, 32'h11223344, 4'h3, rd, er, lat);
    mstore(32'h8, 32'h11223344, 4'h3);
`ifdef DMEM_BYTE_STROBE_EN
    want = 32'hDEAD3344;
`else
    want = 32'h11223344;
`endif
    txn(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (rd !== want || rd !== model[2]) begin bad++; $display("FAIL strobe_load got=%h want=%h", rd, want); end
    txn(1'b1, 32'hC, 32'hCAFEF00D, 4'h0, rd, er, lat);
    mstore(32'hC, 32'hCAFEF00D, 4'h0);
    txn(1'b0, 32'hC, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== model[3]) begin bad++; $display("FAIL zero_strobe got e=%b d=%h want 0/%h", er, rd, model[3]); end
  endtask

  task automatic test_fault();
    logic [31:0] rd; logic er; int lat;
    txn(1'b0, 32'h80, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL fault_load got e=%b d=%h want 1/0", er, rd); end
    txn(1'b1, 32'hA, 32'h55555555, 4'hF, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL fault_store got e=%b d=%h want 1/0", er, rd); end
    txn(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== model[2]) begin bad++; $display("FAIL fault_unchanged got=%h want=%h", rd, model[2]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd0; logic er0; int w;
    @(negedge clk);
    b.req_valid = 1'b1; b.req_write = 1'b0; b.req_addr = 32'h8;
    w = 0;
    while (!b.req_ready && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    b.req_addr = 32'hC;
    w = 1;
    while (!b.rsp_valid && w < 40) begin @(negedge clk); w++; end
    rd0 = b.rsp_rdata; er0 = b.rsp_err;
    total++;
    if (w != 3 || rd0 !== model[2] || er0 !== 1'b0) begin bad++; $display("FAIL bp_first got lat=%0d d=%h e=%b want 3/%h/0", w, rd0, er0, model[2]); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (b.rsp_valid !== 1'b1 || b.rsp_rdata !== rd0 || b.rsp_err !== er0 || b.req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d] got v=%b d=%h e=%b rdy=%b want 1/%h/%b/0", i, b.rsp_valid, b.rsp_rdata, b.rsp_err, b.req_ready, rd0, er0);
      end
    end
    b.rsp_ready = 1'b1;
    @(negedge clk);
    b.rsp_ready = 1'b0;
    total++;
    if (b.req_ready !== 1'b1 || b.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_after_hs got rdy=%b v=%b want 1/0", b.req_ready, b.rsp_valid); end
    @(negedge clk);
    total++;
    if (b.req_ready !== 1'b0) begin bad++; $display("FAIL bp_accept got rdy=%b want 0", b.req_ready); end
    b.req_valid = 1'b0;
    w = 1;
    while (!b.rsp_valid && w < 40) begin @(negedge clk); w++; end
    total++;
    if (w != 3 || b.rsp_rdata !== model[3]) begin bad++; $display("FAIL bp_second got lat=%0d d=%h want 3/%h", w, b.rsp_rdata, model[3]); end
    b.rsp_ready = 1'b1;
    @(negedge clk);
    b.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er; int lat, w;
    logic seen;
    @(negedge clk);
    b.req_valid = 1'b1; b.req_write = 1'b1; b.req_addr = 32'h4; b.req_wdata = $urandom | 32'h1; b.req_wstrb = 4'hF;
    w = 0;
    while (!b.req_ready && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    b.req_valid = 1'b0;
    reset = 1'b0;
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen |= b.rsp_valid; end
    reset = 1'b1;
    mclear();
    @(negedge clk);
    total++;
    if (b.req_ready !== 1'b1) begin bad++; $display("FAIL rst_wait_ready got=%b want=1", b.req_ready); end
    repeat (4) begin @(negedge clk); seen |= b.rsp_valid; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rst_wait_rsp got rsp_valid=%b want 0", seen); end
    txn(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL rst_wait_word got=%h want=0", rd); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] d;
    int w;
    d = $urandom;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      b0.req_valid = 1'b1; b0.req_write = (k == 0); b0.req_addr = 32'h10; b0.req_wdata = d; b0.req_wstrb = 4'hF;
      w = 0;
      while (!b0.req_ready && w < 50) begin @(negedge clk); w++; end
      @(negedge clk);
      b0.req_valid = 1'b0; b0.req_wdata = ~d;
      total++;
      if (b0.rsp_valid !== 1'b1 || b0.rsp_err !== 1'b0 || b0.rsp_rdata !== (k == 0 ? 32'h0 : d)) begin
        bad++; $display("FAIL zero_wait[%0d] got v=%b d=%h e=%b want 1/%h/0", k, b0.rsp_valid, b0.rsp_rdata, b0.rsp_err, k == 0 ? 32'h0 : d);
      end
      b0.rsp_ready = 1'b1;
      @(negedge clk);
      b0.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, want; logic er, wr, ee; logic [3:0] ws; int lat;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 160)) : 32'($urandom_range(0, 35) * 4);
      wd = $urandom;
      ws = 4'($urandom);
      ee = fault(a);
      want = wr ? 32'h0 : mload(a);
      txn(wr, a, wd, ws, rd, er, lat);
      if (wr) mstore(a, wd, ws);
      total++;
      if (lat != 3 || er !== ee || rd !== want) begin
        bad++; $display("FAIL random[%0d] wr=%b a=%h got lat=%0d e=%b d=%h want 3/%b/%h", n, wr, a, lat, er, rd, ee, want);
      end
    end
  endtask

  initial begin
    b.req_valid = 1'b0; b.req_write = 1'b0; b.req_addr = '0; b.req_wdata = '0; b.req_wstrb = '0; b.rsp_ready = 1'b0;
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0; b0.req_wstrb = '0; b0.rsp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_strobe();
    test_fault();
    test_backpressure();
    test_reset_in_wait();
    test_zero_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
